// File: rtl/custom_axi_ip_regs.sv
// custom_axi_ip_regs: AXI4-Lite register file bridging CPU accesses to the custom IP core.
// CTRL starts the core, DATA_IN drives it, DATA_OUT/STATUS capture its write-back.
module custom_axi_ip_regs #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [ADDR_WIDTH-1:0] s_awaddr_i,
   input  logic                  s_awvalid_i,
   output logic                  s_awready_o,
   input  logic [DATA_WIDTH-1:0] s_wdata_i,
   input  logic [3:0]            s_wstrb_i,
   input  logic                  s_wvalid_i,
   output logic                  s_wready_o,
   output logic [1:0]            s_bresp_o,
   output logic                  s_bvalid_o,
   input  logic                  s_bready_i,
   input  logic [ADDR_WIDTH-1:0] s_araddr_i,
   input  logic                  s_arvalid_i,
   output logic                  s_arready_o,
   output logic [DATA_WIDTH-1:0] s_rdata_o,
   output logic [1:0]            s_rresp_o,
   output logic                  s_rvalid_o,
   input  logic                  s_rready_i,
   output logic [DATA_WIDTH-1:0] ipreg_data_o,
   output logic                  enable_o,
   input  logic [DATA_WIDTH-1:0] ipreg_data_i,
   input  logic                  wen_i,
   input  logic [1:0]            status_i,
   input  logic                  enable_i
);
   typedef enum logic {W_IDLE, W_RESP} w_state_e;
   typedef enum logic {R_IDLE, R_RESP} r_state_e;
   w_state_e              w_state_q;
   r_state_e              r_state_q;
   logic                  up_q, aw_got_q, w_got_q, bvalid_q, rvalid_q;
   logic [1:0]            awaddr_q;
   logic [DATA_WIDTH-1:0] wdata_q, rdata_q, data_in_q, data_in_d, data_out_q;
   logic [3:0]            wstrb_q;
   logic                  done_q, done_d, reject_q, reject_d, enable_q, enable_d;
   logic                  aw_hs, w_hs, ar_hs, commit, start, w1c;
   logic [1:0]            c_addr;
   logic [DATA_WIDTH-1:0] c_data, rd_mux, status_word;
   logic [3:0]            c_strb;
   logic                  unused_addr;
   assign unused_addr  = ^{s_awaddr_i[1:0], s_araddr_i[1:0]};
   // Readies stay low while reset is held and rise on the first clock after release.
   assign s_awready_o  = up_q & (w_state_q == W_IDLE) & ~aw_got_q;
   assign s_wready_o   = up_q & (w_state_q == W_IDLE) & ~w_got_q;
   assign s_arready_o  = up_q & (r_state_q == R_IDLE);
   assign s_bvalid_o   = bvalid_q;
   assign s_bresp_o    = 2'b00;
   assign s_rvalid_o   = rvalid_q;
   assign s_rresp_o    = 2'b00;
   assign s_rdata_o    = rdata_q;
   assign ipreg_data_o = data_in_q;
   assign enable_o     = enable_q;
   assign aw_hs  = s_awvalid_i & s_awready_o;
   assign w_hs   = s_wvalid_i & s_wready_o;
   assign ar_hs  = s_arvalid_i & s_arready_o;
   assign commit = (w_state_q == W_IDLE) & (aw_got_q | aw_hs) & (w_got_q | w_hs);
   assign c_addr = aw_got_q ? awaddr_q : s_awaddr_i[3:2];
   assign c_data = w_got_q ? wdata_q : s_wdata_i;
   assign c_strb = w_got_q ? wstrb_q : s_wstrb_i;
   assign start  = commit & (c_addr == 2'd0) & c_strb[0] & c_data[0];
   assign w1c    = commit & (c_addr == 2'd3) & c_strb[1];
   assign status_word = {{(DATA_WIDTH-10){1'b0}}, reject_q, done_q, 5'b0, enable_i, status_i};
   assign rd_mux = s_araddr_i[3:2] == 2'd0 ? '0 :
                   s_araddr_i[3:2] == 2'd1 ? data_in_q :
                   s_araddr_i[3:2] == 2'd2 ? data_out_q : status_word;
   always_comb begin
      data_in_d = data_in_q;
      for (int b = 0; b < 4; b++)
         if (commit && c_addr == 2'd1 && c_strb[b]) data_in_d[8*b +: 8] = c_data[8*b +: 8];
      // Hardware set of DONE takes priority over a same-cycle W1C.
      done_d   = wen_i | (done_q & ~(w1c & c_data[8]));
      reject_d = (start & (status_i != 2'd0)) | (reject_q & ~(w1c & c_data[9]));
      enable_d = start & (status_i == 2'd0);
   end
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         up_q       <= 1'b0;
         data_in_q  <= '0;
         data_out_q <= '0;
         done_q     <= 1'b0;
         reject_q   <= 1'b0;
         enable_q   <= 1'b0;
      end else begin
         up_q       <= 1'b1;
         data_in_q  <= data_in_d;
         data_out_q <= wen_i ? ipreg_data_i : data_out_q;
         done_q     <= done_d;
         reject_q   <= reject_d;
         enable_q   <= enable_d;
      end
   end
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         w_state_q <= W_IDLE;
         aw_got_q  <= 1'b0;
         w_got_q   <= 1'b0;
         bvalid_q  <= 1'b0;
         awaddr_q  <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
      end else if (w_state_q == W_IDLE) begin
         if (aw_hs) awaddr_q <= s_awaddr_i[3:2];
         if (w_hs) begin
            wdata_q <= s_wdata_i;
            wstrb_q <= s_wstrb_i;
         end
         aw_got_q  <= commit ? 1'b0 : (aw_got_q | aw_hs);
         w_got_q   <= commit ? 1'b0 : (w_got_q | w_hs);
         bvalid_q  <= commit;
         w_state_q <= commit ? W_RESP : W_IDLE;
      end else if (s_bready_i) begin
         bvalid_q  <= 1'b0;
         w_state_q <= W_IDLE;
      end
   end
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state_q <= R_IDLE;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
      end else if (r_state_q == R_IDLE) begin
         if (ar_hs) begin
            rdata_q   <= rd_mux;
            rvalid_q  <= 1'b1;
            r_state_q <= R_RESP;
         end
      end else if (s_rready_i) begin
         rvalid_q  <= 1'b0;
         r_state_q <= R_IDLE;
      end
   end
endmodule

// File: tb/tb_custom_axi_ip_regs.sv
// tb_custom_axi_ip_regs: directed and randomized checks of the register file against a register-map model.
module tb_custom_axi_ip_regs;
   logic        clk_i = 0, rst_i = 1;
   logic [3:0]  s_awaddr_i = 0, s_araddr_i = 0, s_wstrb_i = 0;
   logic        s_awvalid_i = 0, s_wvalid_i = 0, s_bready_i = 0, s_arvalid_i = 0, s_rready_i = 0;
   logic        s_awready_o, s_wready_o, s_bvalid_o, s_arready_o, s_rvalid_o, enable_o;
   logic [1:0]  s_bresp_o, s_rresp_o;
   logic [31:0] s_wdata_i = 0, s_rdata_o, ipreg_data_o, ipreg_data_i = 0;
   logic        wen_i = 0, enable_i = 0;
   logic [1:0]  status_i = 0;
   int          n_tests = 0, n_fail = 0, en_cnt = 0, exp_en = 0;
   logic [31:0] m_din = 0, m_dout = 0;
   logic        m_done = 0, m_rej = 0;

   custom_axi_ip_regs dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .s_awaddr_i(s_awaddr_i), .s_awvalid_i(s_awvalid_i), .s_awready_o(s_awready_o),
      .s_wdata_i(s_wdata_i), .s_wstrb_i(s_wstrb_i), .s_wvalid_i(s_wvalid_i), .s_wready_o(s_wready_o),
      .s_bresp_o(s_bresp_o), .s_bvalid_o(s_bvalid_o), .s_bready_i(s_bready_i),
      .s_araddr_i(s_araddr_i), .s_arvalid_i(s_arvalid_i), .s_arready_o(s_arready_o),
      .s_rdata_o(s_rdata_o), .s_rresp_o(s_rresp_o), .s_rvalid_o(s_rvalid_o), .s_rready_i(s_rready_i),
      .ipreg_data_o(ipreg_data_o), .enable_o(enable_o), .ipreg_data_i(ipreg_data_i),
      .wen_i(wen_i), .status_i(status_i), .enable_i(enable_i)
   );

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) if (enable_o) en_cnt++;

   function automatic logic [31:0] exp_rd(input logic [3:0] a);
      case (a[3:2])
         2'd0: return 32'h0;
         2'd1: return m_din;
         2'd2: return m_dout;
         default: return {22'h0, m_rej, m_done, 5'h0, enable_i, status_i};
      endcase
   endfunction

   function automatic void model_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
      if (a[3:2] == 2'd1) begin
         for (int b = 0; b < 4; b++) if (s[b]) m_din[8*b +: 8] = d[8*b +: 8];
      end else if (a[3:2] == 2'd0 && s[0] && d[0]) begin
         if (status_i == 2'd0) exp_en++;
         else m_rej = 1;
      end else if (a[3:2] == 2'd3 && s[1]) begin
         if (d[8]) m_done = 0;
         if (d[9]) m_rej = 0;
      end
   endfunction

   task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
      logic af, wf, b;
      int n;
      s_awaddr_i = a; s_wdata_i = d; s_wstrb_i = s;
      s_awvalid_i = 1; s_wvalid_i = 1; s_bready_i = 1; n = 0; b = 0;
      while ((s_awvalid_i || s_wvalid_i) && n < 20) begin
         af = s_awvalid_i & s_awready_o;
         wf = s_wvalid_i & s_wready_o;
         @(posedge clk_i); #1;
         if (af) s_awvalid_i = 0;
         if (wf) s_wvalid_i = 0;
         n++;
      end
      while (!b && n < 40) begin
         b = s_bvalid_o;
         if (b) begin
            n_tests++;
            if (s_bresp_o !== 2'b00) begin n_fail++; $display("FAIL bresp addr=%h got=%b exp=00", a, s_bresp_o); end
         end
         @(posedge clk_i); #1;
         n++;
      end
      if (!b) begin n_tests++; n_fail++; $display("FAIL write_timeout addr=%h got=no_bvalid exp=bvalid", a); end
      s_awvalid_i = 0; s_wvalid_i = 0; s_bready_i = 0;
      model_write(a, d, s);
   endtask

   task automatic axi_read(input logic [3:0] a, output logic [31:0] d, output logic [1:0] r);
      logic f, v;
      int n;
      s_araddr_i = a; s_arvalid_i = 1; s_rready_i = 1; n = 0; f = 0; v = 0; d = 0; r = 0;
      while (!f && n < 20) begin
         f = s_arready_o;
         @(posedge clk_i); #1;
         n++;
      end
      s_arvalid_i = 0;
      while (!v && n < 40) begin
         v = s_rvalid_o; d = s_rdata_o; r = s_rresp_o;
         @(posedge clk_i); #1;
         n++;
      end
      s_rready_i = 0;
      if (!v) begin n_tests++; n_fail++; $display("FAIL read_timeout addr=%h got=no_rvalid exp=rvalid", a); end
   endtask

   task automatic core_wb(input logic [31:0] d);
      ipreg_data_i = d; wen_i = 1;
      @(posedge clk_i); #1;
      wen_i = 0;
      m_dout = d; m_done = 1;
   endtask

   task automatic test_reset;
      logic [31:0] d;
      logic [1:0] r;
      n_tests++;
      if ({s_awready_o, s_wready_o, s_arready_o} !== 3'b111) begin n_fail++; $display("FAIL reset_readies got=%b exp=111", {s_awready_o, s_wready_o, s_arready_o}); end
      n_tests++;
      if ({s_bvalid_o, s_rvalid_o, enable_o, ipreg_data_o} !== 35'h0) begin n_fail++; $display("FAIL reset_outputs got=%h exp=0", {s_bvalid_o, s_rvalid_o, enable_o, ipreg_data_o}); end
      axi_write(4'h4, 32'hDEAD_BEEF, 4'hF);
      s_awaddr_i = 4'h4; s_awvalid_i = 1; s_wvalid_i = 0;
      @(posedge clk_i); #1;
      s_awvalid_i = 0;
      n_tests++;
      if (s_awready_o !== 1'b0) begin n_fail++; $display("FAIL aw_latched got=%b exp=0", s_awready_o); end
      rst_i = 1; #2;
      n_tests++;
      if ({s_bvalid_o, s_awready_o, s_wready_o, ipreg_data_o} !== 35'h0) begin n_fail++; $display("FAIL in_reset got=%h exp=0", {s_bvalid_o, s_awready_o, s_wready_o, ipreg_data_o}); end
      @(posedge clk_i); #1;
      rst_i = 0;
      m_din = 0; m_dout = 0; m_done = 0; m_rej = 0;
      @(posedge clk_i); #1;
      n_tests++;
      if ({s_awready_o, s_wready_o, s_bvalid_o} !== 3'b110) begin n_fail++; $display("FAIL post_reset got=%b exp=110", {s_awready_o, s_wready_o, s_bvalid_o}); end
      repeat (3) begin
         @(posedge clk_i); #1;
         n_tests++;
         if (s_bvalid_o !== 1'b0) begin n_fail++; $display("FAIL stale_bresp got=%b exp=0", s_bvalid_o); end
      end
      axi_read(4'h4, d, r);
      n_tests++;
      if (d !== 32'h0) begin n_fail++; $display("FAIL reset_data_in got=%h exp=0", d); end
   endtask

   task automatic test_data_in;
      logic [31:0] d;
      logic [1:0] r;
      axi_write(4'h4, 32'h0000_1234, 4'b0011);
      axi_write(4'h4, 32'hAB00_0000, 4'b1000);
      axi_read(4'h4, d, r);
      n_tests++;
      if (d !== 32'hAB00_1234 || r !== 2'b00) begin n_fail++; $display("FAIL data_in_read got=%h/%b exp=ab001234/00", d, r); end
      n_tests++;
      if (ipreg_data_o !== 32'hAB00_1234) begin n_fail++; $display("FAIL ipreg_data got=%h exp=ab001234", ipreg_data_o); end
      axi_write(4'h0, 32'h0, 4'hF);
      axi_read(4'h0, d, r);
      n_tests++;
      if (d !== 32'h0) begin n_fail++; $display("FAIL ctrl_read got=%h exp=0", d); end
      axi_write(4'h8, 32'hFFFF_FFFF, 4'hF);
      axi_read(4'h8, d, r);
      n_tests++;
      if (d !== m_dout || r !== 2'b00) begin n_fail++; $display("FAIL ro_write got=%h exp=%h", d, m_dout); end
   endtask

   task automatic test_decoupled;
      int hb;
      @(posedge clk_i); #1;
      s_wdata_i = 32'h1357_9BDF; s_wstrb_i = 4'hF; s_wvalid_i = 1; s_awvalid_i = 0; s_bready_i = 0;
      @(posedge clk_i); #1;
      s_wvalid_i = 0;
      n_tests++;
      if ({s_wready_o, s_awready_o} !== 2'b01) begin n_fail++; $display("FAIL w_latched got=%b exp=01", {s_wready_o, s_awready_o}); end
      repeat (2) begin
         @(posedge clk_i); #1;
         n_tests++;
         if (s_bvalid_o !== 1'b0 || ipreg_data_o !== m_din) begin n_fail++; $display("FAIL early_commit got=%b/%h exp=0/%h", s_bvalid_o, ipreg_data_o, m_din); end
      end
      s_awaddr_i = 4'h4; s_awvalid_i = 1;
      @(posedge clk_i); #1;
      s_awvalid_i = 0;
      model_write(4'h4, 32'h1357_9BDF, 4'hF);
      hb = 0;
      repeat (5) begin
         hb += int'(s_bvalid_o);
         @(posedge clk_i); #1;
      end
      n_tests++;
      if (hb != 5) begin n_fail++; $display("FAIL bvalid_hold got=%0d exp=5", hb); end
      s_bready_i = 1;
      @(posedge clk_i); #1;
      s_bready_i = 0;
      hb = 0;
      repeat (4) begin
         hb += int'(s_bvalid_o);
         @(posedge clk_i); #1;
      end
      n_tests++;
      if (hb != 0) begin n_fail++; $display("FAIL extra_bresp got=%0d exp=0", hb); end
      n_tests++;
      if (ipreg_data_o !== m_din || {s_awready_o, s_wready_o} !== 2'b11) begin n_fail++; $display("FAIL decoupled_update got=%h exp=%h", ipreg_data_o, m_din); end
   endtask

   task automatic test_start;
      logic [31:0] d;
      logic [1:0] r;
      int e0;
      status_i = 2'd0; e0 = en_cnt;
      axi_write(4'h0, 32'h1, 4'h1);
      repeat (3) @(posedge clk_i);
      #1;
      n_tests++;
      if (en_cnt - e0 != 1) begin n_fail++; $display("FAIL start_pulse got=%0d exp=1", en_cnt - e0); end
      core_wb(32'h55);
      axi_read(4'h8, d, r);
      n_tests++;
      if (d !== 32'h55) begin n_fail++; $display("FAIL data_out got=%h exp=55", d); end
      axi_read(4'hC, d, r);
      n_tests++;
      if (d[8] !== 1'b1) begin n_fail++; $display("FAIL done_set got=%b exp=1", d[8]); end
      axi_write(4'hC, 32'h100, 4'h2);
      axi_read(4'hC, d, r);
      n_tests++;
      if (d[8] !== 1'b0) begin n_fail++; $display("FAIL done_clear got=%b exp=0", d[8]); end
   endtask

   task automatic test_reject;
      logic [31:0] d;
      logic [1:0] r;
      int e0;
      status_i = 2'd1; e0 = en_cnt;
      axi_write(4'h0, 32'h1, 4'h1);
      repeat (3) @(posedge clk_i);
      #1;
      n_tests++;
      if (en_cnt != e0) begin n_fail++; $display("FAIL reject_pulse got=%0d exp=0", en_cnt - e0); end
      axi_read(4'hC, d, r);
      n_tests++;
      if (d[9] !== 1'b1 || d[1:0] !== 2'd1) begin n_fail++; $display("FAIL reject_status got=%h exp=bit9,st=1", d); end
      axi_write(4'hC, 32'h200, 4'h2);
      status_i = 2'd0;
   endtask

   task automatic test_collision;
      logic [31:0] d, old;
      logic [1:0] r;
      int n;
      core_wb(32'hA5A5);
      s_awaddr_i = 4'hC; s_wdata_i = 32'h100; s_wstrb_i = 4'h2;
      s_awvalid_i = 1; s_wvalid_i = 1; s_bready_i = 1; ipreg_data_i = 32'h77; wen_i = 1;
      @(posedge clk_i); #1;
      s_awvalid_i = 0; s_wvalid_i = 0; wen_i = 0;
      n = 0;
      while (!s_bvalid_o && n < 10) begin @(posedge clk_i); #1; n++; end
      @(posedge clk_i); #1;
      s_bready_i = 0;
      m_dout = 32'h77; m_done = 1;
      axi_read(4'hC, d, r);
      n_tests++;
      if (d[8] !== 1'b1) begin n_fail++; $display("FAIL set_beats_clear got=%b exp=1", d[8]); end
      old = m_dout;
      s_araddr_i = 4'h8; s_arvalid_i = 1; s_rready_i = 0; ipreg_data_i = 32'hC0DE; wen_i = 1;
      @(posedge clk_i); #1;
      s_arvalid_i = 0; wen_i = 0;
      m_dout = 32'hC0DE;
      n_tests++;
      if (s_rvalid_o !== 1'b1 || s_rdata_o !== old) begin n_fail++; $display("FAIL read_vs_wen got=%b/%h exp=1/%h", s_rvalid_o, s_rdata_o, old); end
      s_rready_i = 1;
      @(posedge clk_i); #1;
      s_rready_i = 0;
   endtask

   task automatic test_random;
      logic [31:0] d, wd;
      logic [3:0] a, s;
      logic [1:0] r;
      for (int i = 0; i < 80; i++) begin
         case ($urandom_range(0, 3))
            0: begin
               a = 4'($urandom_range(0, 15)); wd = $urandom; s = 4'($urandom_range(0, 15));
               axi_write(a, wd, s);
               @(posedge clk_i); #1;
               n_tests++;
               if (en_cnt != exp_en) begin n_fail++; $display("FAIL rand_pulses got=%0d exp=%0d", en_cnt, exp_en); end
            end
            1: begin
               a = 4'($urandom_range(0, 15));
               axi_read(a, d, r);
               n_tests++;
               if (d !== exp_rd(a) || r !== 2'b00) begin n_fail++; $display("FAIL rand_read addr=%h got=%h exp=%h", a, d, exp_rd(a)); end
            end
            2: core_wb($urandom);
            default: begin
               status_i = 2'($urandom_range(0, 3)); enable_i = 1'($urandom_range(0, 1));
            end
         endcase
      end
   endtask

   initial begin
      repeat (3) @(posedge clk_i);
      #1;
      rst_i = 0;
      @(posedge clk_i); #1;
      test_reset;
      test_data_in;
      test_decoupled;
      test_start;
      test_reject;
      test_collision;
      test_random;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/custom_axi_ip_regs.md
Name: custom_axi_ip_regs

Overview:
AXI4-Lite subordinate register file on the software side of the custom AXI IP core's register-to-hardware interface. It turns CPU register accesses into the core's data and enable inputs, and captures the core's write-back data, write-enable and status for readback. One outstanding write and one outstanding read at a time.

Parameters:
ADDR_WIDTH, 4, byte address width; only addr[3:2] is decoded, addr[1:0] is ignored.
DATA_WIDTH, 32, AXI data width; only 32 is supported.

Ports:
clk_i  in  1  system clock.
rst_i  in  1  asynchronous, active-high reset.
s_awaddr_i  in  ADDR_WIDTH  write address.
s_awvalid_i  in  1  write-address valid.
s_awready_o  out  1  write-address ready.
s_wdata_i  in  32  write data.
s_wstrb_i  in  4  write byte strobes.
s_wvalid_i  in  1  write-data valid.
s_wready_o  out  1  write-data ready.
s_bresp_o  out  2  write response.
s_bvalid_o  out  1  write-response valid.
s_bready_i  in  1  write-response ready.
s_araddr_i  in  ADDR_WIDTH  read address.
s_arvalid_i  in  1  read-address valid.
s_arready_o  out  1  read-address ready.
s_rdata_o  out  32  read data.
s_rresp_o  out  2  read response.
s_rvalid_o  out  1  read valid.
s_rready_i  in  1  read ready.
ipreg_data_o  out  32  DATA_IN register value driven to the core.
enable_o  out  1  one-cycle start pulse to the core.
ipreg_data_i  in  32  write-back data from the core.
wen_i  in  1  core write-back strobe.
status_i  in  2  core state (status_e).
enable_i  in  1  core enable echo, readable in STATUS.

Behaviour:
- Reset, asynchronous on rst_i high. All AXI ready/valid outputs are 0; bresp, rresp and rdata are 0. DATA_IN, DATA_OUT and the sticky bits clear to 0. enable_o is 0.
- Register map (word offset):
  - 0x0 CTRL: W bit0 START; reads 0.
  - 0x4 DATA_IN: RW, byte-strobed.
  - 0x8 DATA_OUT: RO.
  - 0xC STATUS: RO [1:0] status_i, [2] enable_i; W1C [8] DONE, [9] REJECT; other bits read 0.
- status_e encoding: IDLE=0, BUSY=1, DONE=2, ERROR=3.
- Write FSM, states W_IDLE, W_RESP:
  - W_IDLE: awready and wready are both high. AW and W may arrive in either order or together.
  - Each handshaken channel is latched, and its ready drops until the other channel arrives.
  - When both are latched, the register update happens in that cycle, bvalid rises on the next cycle, and the FSM moves to W_RESP.
  - W_RESP: bvalid and bresp are held stable until bready; then the FSM returns to W_IDLE with both readies high the following cycle.
- Read FSM, states R_IDLE, R_RESP:
  - R_IDLE: arready is high. An AR handshake captures the decoded data into rdata, raises rvalid on the next cycle (latency 1) and moves to R_RESP.
  - R_RESP: arready is 0; rdata, rresp and rvalid are held until rready, then the FSM returns to R_IDLE.
- Responses: every offset listed above returns OKAY (2'b00). Writes to RO offsets are ignored and return OKAY. With a 4-bit address there are no unmapped offsets.
- START:
  - Writing CTRL with wstrb[0]=1 and wdata[0]=1 while status_i==IDLE pulses enable_o high for exactly 1 cycle, the cycle after the write commit.
  - If status_i!=IDLE, no pulse is issued and REJECT is set.
- Core write-back: wen_i high captures ipreg_data_i into DATA_OUT and sets DONE, both on that clock edge.
- Simultaneous events:
  - A W1C clear and a hardware set of DONE in the same cycle: the set wins.
  - A read of DATA_OUT in the same cycle as wen_i returns the old value.
- Concurrent read and write are independent. A write commit in the same cycle as an AR: the read sees the pre-write value.
- Reset mid-transaction abandons all in-flight handshakes; no response is issued after reset.

Test Plan:
- Reset check: assert rst_i mid-write, after the AW handshake -> bvalid=0, awready=wready=1 after release, DATA_IN=0.
- Write and read DATA_IN: write 0x0000_1234 with wstrb=4'b0011, then 0xAB00_0000 with wstrb=4'b1000 -> read of 0x4 returns 0xAB00_1234 with rresp OKAY; ipreg_data_o equals it.
- Decoupled channels: W presented 3 cycles before AW, bready held low 5 cycles -> single update, bvalid held 5 cycles, exactly one response.
- Start flow: status_i=IDLE, write CTRL=1 -> enable_o high exactly 1 cycle; then wen_i with ipreg_data_i=0x55 -> DATA_OUT=0x55, STATUS bit8=1; W1C 0x100 -> bit8=0.
- Reject: status_i=BUSY, write CTRL=1 -> no enable_o pulse, STATUS bit9=1, STATUS[1:0]=1.
- Set/clear collision: W1C of DONE in the same cycle as wen_i -> DONE remains 1.
